// File: rtl/dec_frame_counter_pkg.sv
// Shared channel-coder definitions: frame geometry, index width and the
// frame sequencing state encoding used by both decoder and encoder sides.
package dec_frame_counter_pkg;

  localparam int K_LARGE  = 6144;
  localparam int K_SMALL  = 1056;
  localparam int TAIL_LEN = 4;
  localparam int CW       = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dec_idx_counter.sv
// Frame index counter: synchronous clear has priority over increment.
module dec_idx_counter
  import dec_frame_counter_pkg::*;
#(
  parameter int WIDTH = CW
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // index register; the controller never enables past the last index
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dec_frame_counter.sv
// Decoder input frame sequencer: tags each accepted LLR triplet as data or
// tail, tracks its index within the frame and flags frame boundaries.
//
// state | meaning
// IDLE  | waiting for the first data triplet; mode is sampled on acceptance
// DATA  | accepting data triplets 1..K-1
// TAIL  | accepting tail triplets 0..TAIL_LEN-1
// DONE  | one-cycle gap after the last tail triplet; input stalled
module dec_frame_counter #(
  parameter int K_LARGE  = dec_frame_counter_pkg::K_LARGE,
  parameter int K_SMALL  = dec_frame_counter_pkg::K_SMALL,
  parameter int TAIL_LEN = dec_frame_counter_pkg::TAIL_LEN,
  parameter int W        = 8,
  parameter int CW       = dec_frame_counter_pkg::CW
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          mode,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [W-1:0]  in_sys,
  input  logic [W-1:0]  in_p1,
  input  logic [W-1:0]  in_p2,
  output logic          in_ready,
  output logic [W-1:0]  out_sys,
  output logic [W-1:0]  out_p1,
  output logic [W-1:0]  out_p2,
  output logic          data_valid,
  output logic          tail_valid,
  output logic [CW-1:0] idx,
  output logic          sop,
  output logic          eop,
  output logic          frame_done,
  output logic          frame_mode
);

  import dec_frame_counter_pkg::*;

  localparam logic [CW-1:0] LAST_LARGE = CW'(K_LARGE - 1);
  localparam logic [CW-1:0] LAST_SMALL = CW'(K_SMALL - 1);
  localparam logic [CW-1:0] LAST_TAIL  = CW'(TAIL_LEN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt;
  logic          cnt_en, cnt_clr;
  logic          accept;
  logic          mode_sel;
  logic [CW-1:0] last_data;
  logic          in_data_phase;

  assign in_ready      = (state_q != DONE);
  assign accept        = in_valid && in_ready;
  assign in_data_phase = (state_q == IDLE) || (state_q == DATA);
  // the live mode pin only matters for the first triplet of a frame
  assign mode_sel      = (state_q == IDLE) ? mode : frame_mode;
  assign last_data     = mode_sel ? LAST_SMALL : LAST_LARGE;

  dec_idx_counter #(.WIDTH(CW)) u_idx_counter (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .cnt   (cnt)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and counter control; abort overrides any acceptance
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, DATA: begin
          if (accept) begin
            if (cnt == last_data) begin
              state_d = TAIL;
              cnt_clr = 1'b1;
            end else begin
              state_d = DATA;
              cnt_en  = 1'b1;
            end
          end
        end
        TAIL: begin
          if (accept) begin
            if (cnt == LAST_TAIL) begin
              state_d = DONE;
              cnt_clr = 1'b1;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // output registers: one cycle behind acceptance; data held when idle.
  // frame_done follows the DONE state by one cycle so it lands right after
  // the last tail_valid rather than on top of it.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      out_sys    <= '0;
      out_p1     <= '0;
      out_p2     <= '0;
      idx        <= '0;
      data_valid <= 1'b0;
      tail_valid <= 1'b0;
      sop        <= 1'b0;
      eop        <= 1'b0;
      frame_done <= 1'b0;
      frame_mode <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      tail_valid <= 1'b0;
      sop        <= 1'b0;
      eop        <= 1'b0;
      frame_done <= (state_q == DONE);
      if (accept && !abort) begin
        out_sys    <= in_sys;
        out_p1     <= in_p1;
        out_p2     <= in_p2;
        idx        <= cnt;
        data_valid <= in_data_phase;
        tail_valid <= (state_q == TAIL);
        sop        <= (state_q == IDLE);
        eop        <= in_data_phase && (cnt == last_data);
        if (state_q == IDLE) begin
          frame_mode <= mode;
        end
      end
    end
  end

endmodule

// File: tb/tb_dec_frame_counter.sv
// Scoreboard bench for dec_frame_counter: the driver pushes the expected
// output record for every triplet it knows will be accepted (plus one for
// each frame_done), and a negedge monitor pops and compares.
module tb_dec_frame_counter;

  localparam int W       = 8;
  localparam int CW      = 13;
  localparam int KL      = 6144;
  localparam int KS      = 1056;
  localparam int TL      = 4;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          mode = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_sys = '0, in_p1 = '0, in_p2 = '0;
  logic          in_ready;
  logic [W-1:0]  out_sys, out_p1, out_p2;
  logic          data_valid, tail_valid, sop, eop, frame_done, frame_mode;
  logic [CW-1:0] idx;

  typedef struct {
    int           kind;   // 0 data, 1 tail, 2 frame_done
    int           idx;
    logic         sop;
    logic         eop;
    logic         fm;
    logic [W-1:0] s;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  dec_frame_counter #(
    .K_LARGE(KL), .K_SMALL(KS), .TAIL_LEN(TL), .W(W), .CW(CW)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .mode       (mode),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_sys     (in_sys),
    .in_p1      (in_p1),
    .in_p2      (in_p2),
    .in_ready   (in_ready),
    .out_sys    (out_sys),
    .out_p1     (out_p1),
    .out_p2     (out_p2),
    .data_valid (data_valid),
    .tail_valid (tail_valid),
    .idx        (idx),
    .sop        (sop),
    .eop        (eop),
    .frame_done (frame_done),
    .frame_mode (frame_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] gen(input int fr, input int kind, input int i);
    int v;
    v = fr * 977 + kind * 131 + i * 40503;
    return 24'(v) ^ 24'h5a3c96;
  endfunction

  task automatic drive(input logic v, input logic [23:0] d, input logic m,
                       input logic ab, input logic rn);
    @(posedge clk);
    #2;
    in_valid = v;
    in_sys   = d[23:16];
    in_p1    = d[15:8];
    in_p2    = d[7:0];
    mode     = m;
    abort    = ab;
    clr_n    = rn;
  endtask

  task automatic send(input int kind, input int i, input int fr, input logic fm,
                      input logic m, input int k);
    exp_t        e;
    logic [23:0] d;
    d      = gen(fr, kind, i);
    e.kind = kind;
    e.idx  = i;
    e.sop  = (kind == 0) && (i == 0);
    e.eop  = (kind == 0) && (i == k - 1);
    e.fm   = fm;
    e.s    = d[23:16];
    e.a    = d[15:8];
    e.b    = d[7:0];
    drive(1'b1, d, m, 1'b0, 1'b1);
    q.push_back(e);
  endtask

  task automatic idle(input logic m);
    drive(1'b0, 24'($urandom), m, 1'b0, 1'b1);
  endtask

  // the DONE cycle: input stalled; optionally offer a triplet that must be ignored
  task automatic end_cycle(input bit busy, input logic m);
    exp_t e;
    drive(busy, 24'($urandom), m, 1'b0, 1'b1);
    check("in_ready_done", {31'b0, in_ready}, 32'd0);
    e.kind = 2; e.idx = 0; e.sop = 0; e.eop = 0; e.fm = 0; e.s = '0; e.a = '0; e.b = '0;
    q.push_back(e);
  endtask

  task automatic send_frame(input int fr, input logic fm, input int tog,
                            input bit gaps, input bit busy_done);
    int   k;
    int   i;
    int   c;
    logic m;
    k = fm ? KS : KL;
    i = 0;
    c = 0;
    while (i < k + TL) begin
      m = (tog >= 0 && i >= tog) ? ~fm : fm;
      if (gaps && (c % 3 == 2)) begin
        idle(m);
      end else begin
        if (i < k) send(0, i, fr, fm, m, k);
        else       send(1, i - k, fr, fm, m, k);
        i++;
      end
      c++;
    end
    end_cycle(busy_done, fm);
  endtask

  // monitor: pop on every output event, otherwise confirm the data is held
  initial begin : monitor
    exp_t          e;
    logic [W-1:0]  ls, la, lb;
    logic [CW-1:0] lidx;
    int            gk;
    ls = '0; la = '0; lb = '0; lidx = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (frame_done) begin
          if (q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_frame_done got=1 exp=0 at %0t", $time);
          end else begin
            e = q.pop_front();
            check("done_order_kind", 32'd2, e.kind);
          end
        end
        if (data_valid || tail_valid) begin
          if (q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_valid got dv=%0b tv=%0b idx=%0d exp none at %0t",
                     data_valid, tail_valid, idx, $time);
          end else begin
            e  = q.pop_front();
            gk = (data_valid && !tail_valid) ? 0 : ((tail_valid && !data_valid) ? 1 : 3);
            check("out_kind", gk, e.kind);
            check("out_idx", {19'b0, idx}, e.idx);
            check("out_sop", {31'b0, sop}, {31'b0, e.sop});
            check("out_eop", {31'b0, eop}, {31'b0, e.eop});
            check("out_frame_mode", {31'b0, frame_mode}, {31'b0, e.fm});
            check("out_data", {8'b0, out_sys, out_p1, out_p2}, {8'b0, e.s, e.a, e.b});
            ls = e.s; la = e.a; lb = e.b; lidx = CW'(e.idx);
          end
        end else begin
          check("hold_data", {8'b0, out_sys, out_p1, out_p2}, {8'b0, ls, la, lb});
          check("hold_idx", {19'b0, idx}, {19'b0, lidx});
        end
        // a reset applied now clears the outputs at the coming edge
        if (!clr_n) begin
          ls = '0; la = '0; lb = '0; lidx = '0;
        end
      end
    end
  end

  initial begin : driver
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_valid", {31'b0, data_valid}, 32'd0);
    check("rst_tail_valid", {31'b0, tail_valid}, 32'd0);
    check("rst_flags", {28'b0, sop, eop, frame_done, frame_mode}, 32'd0);
    check("rst_idx", {19'b0, idx}, 32'd0);
    check("rst_data", {8'b0, out_sys, out_p1, out_p2}, 32'd0);
    drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b1);
    check("in_ready_after_release", {31'b0, in_ready}, 32'd1);
    mon_en = 1'b1;

    // large frame, continuous input
    send_frame(1, 1'b0, -1, 1'b0, 1'b0);
    idle(1'b0);
    // small frame with a gap every third cycle
    send_frame(2, 1'b1, -1, 1'b1, 1'b0);
    idle(1'b1);
    // small frame with mode flipped from data index 500 onward
    send_frame(7, 1'b1, 500, 1'b0, 1'b0);
    idle(1'b0);

    // abort while offering data index 10
    for (int i = 0; i < 10; i++) send(0, i, 3, 1'b1, 1'b1, KS);
    drive(1'b1, gen(3, 0, 10), 1'b1, 1'b1, 1'b1);
    repeat (3) idle(1'b1);

    // fresh frame after abort, then reset while offering tail index 2
    for (int i = 0; i < KS; i++) send(0, i, 4, 1'b1, 1'b1, KS);
    send(1, 0, 4, 1'b1, 1'b1, KS);
    send(1, 1, 4, 1'b1, 1'b1, KS);
    drive(1'b1, gen(4, 1, 2), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("midrst_valid", {30'b0, data_valid, tail_valid}, 32'd0);
    check("midrst_flags", {28'b0, sop, eop, frame_done, frame_mode}, 32'd0);
    check("midrst_idx", {19'b0, idx}, 32'd0);
    check("midrst_data", {8'b0, out_sys, out_p1, out_p2}, 32'd0);
    drive(1'b0, 24'd0, 1'b1, 1'b0, 1'b1);
    check("in_ready_after_midrst", {31'b0, in_ready}, 32'd1);
    repeat (3) idle(1'b1);

    // back-to-back frames; a triplet offered during DONE must be ignored
    send_frame(5, 1'b1, -1, 1'b0, 1'b1);
    send_frame(6, 1'b1, -1, 1'b0, 1'b0);
    repeat (4) idle(1'b1);

    @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
